// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch sequencer feeding decode from the IROM through a prefetch FIFO
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rom_req, rom_addr, rom_data      IROM word read, data returns one cycle after rom_req
//   redirect_valid, redirect_pc      fetch restart from execute (flushes buffered and in-flight words)
//   inst_valid, inst, inst_pc        show-ahead FIFO head towards decode
//   inst_ready                       decode accepts the head
module ifetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW:0]   occ;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reserving a slot for the outstanding read guarantees every response has room.
    // rst_n gates the strobe so no read is issued while reset is held.
    assign occ        = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign rom_req    = rst_n && !redirect_valid && (occ < (CW + 1)'(DEPTH));
    assign rom_addr   = fetch_pc[17:2];
    assign push       = inflight && !redirect_valid;
    assign inst_valid = count != '0;
    assign pop        = inst_valid && inst_ready;
    assign inst       = mem_inst[rd_ptr];
    assign inst_pc    = mem_pc[rd_ptr];

    always_comb begin
        count_nxt = (push && !pop) ? count + 1'b1 :
                    (!push && pop) ? count - 1'b1 : count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= rom_req;
            count    <= count_nxt;
            if (rom_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (push) begin
                mem_pc[wr_ptr]   <= inflight_pc;
                mem_inst[wr_ptr] <= rom_data;
                wr_ptr           <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
        end
    end
endmodule
